// File: rtl/jt900h_core.sv
// jt900h_core: reduced TLCS-900H-style CPU core.
// Fetches one instruction byte per enabled cycle from a 16-bit program memory,
// executes immediate loads, bank selection (LDF) and absolute jumps, and
// exposes the 80-byte register file through a registered byte-wide dump port.
module jt900h_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    output logic [23:0] ram_addr,
    input  logic [15:0] ram_dout,
    input  logic [7:0]  dmp_addr,
    output logic [7:0]  dmp_din
);

    typedef enum logic [0:0] {
        FETCH_OP  = 1'b0,
        FETCH_IMM = 1'b1
    } state_t;

    // Number of immediate bytes that follow an opcode; unlisted opcodes are NOPs.
    function automatic logic [2:0] imm_len(input logic [7:0] op);
        logic [2:0] len;
        casez (op)
            8'h17:        len = 3'd1;
            8'h1A:        len = 3'd2;
            8'h1B:        len = 3'd3;
            8'b0010_0???: len = 3'd1;
            8'b0011_0???: len = 3'd2;
            8'b0100_0???: len = 3'd4;
            default:      len = 3'd0;
        endcase
        return len;
    endfunction

    state_t      state_r, state_nx_s;
    logic [7:0]  op_r, op_nx_s;
    logic [2:0]  cnt_r, cnt_nx_s;
    logic [23:0] buf_r, buf_nx_s;
    logic [23:0] pc_r, pc_nx_s;
    logic [1:0]  rfp_r, rfp_nx_s;
    logic [7:0]  regs_r [80];
    logic [7:0]  dmp_din_r;

    logic [7:0]  fbyte_s;
    logic [31:0] shift_s;
    logic [31:0] imm_s;
    logic [6:0]  bank_base_s;
    logic [6:0]  reg_base_s;
    logic        wr_en_s;
    logic [6:0]  wr_base_s;
    logic [2:0]  wr_len_s;
    logic [31:0] wr_data_s;
    logic [79:0] be_s;
    logic [7:0]  bd_s [80];

    // Byte selection, register addressing and the FETCH_OP/FETCH_IMM next-state logic.
    always_comb begin
        fbyte_s     = pc_r[0] ? ram_dout[15:8] : ram_dout[7:0];
        // Immediates shift in from the top so the last byte lands in the MSB.
        shift_s     = {fbyte_s, buf_r};
        bank_base_s = {1'b0, rfp_r, 4'b0000};
        reg_base_s  = op_r[2] ? (7'd64 + {3'b000, op_r[1:0], 2'b00})
                              : (bank_base_s + {3'b000, op_r[1:0], 2'b00});
        state_nx_s  = state_r;
        op_nx_s     = op_r;
        cnt_nx_s    = cnt_r;
        buf_nx_s    = buf_r;
        pc_nx_s     = pc_r + 24'd1;
        rfp_nx_s    = rfp_r;
        imm_s       = 32'd0;
        wr_en_s     = 1'b0;
        wr_base_s   = 7'd0;
        wr_len_s    = 3'd0;
        wr_data_s   = 32'd0;
        case (state_r)
            FETCH_OP: begin
                op_nx_s  = fbyte_s;
                cnt_nx_s = imm_len(fbyte_s);
                buf_nx_s = 24'd0;
                if (imm_len(fbyte_s) != 3'd0) begin
                    state_nx_s = FETCH_IMM;
                end else begin
                    state_nx_s = FETCH_OP;
                end
            end
            FETCH_IMM: begin
                buf_nx_s = shift_s[31:8];
                cnt_nx_s = cnt_r - 3'd1;
                if (cnt_r == 3'd1) begin
                    state_nx_s = FETCH_OP;
                    case (imm_len(op_r))
                        3'd1:    imm_s = {24'd0, shift_s[31:24]};
                        3'd2:    imm_s = {16'd0, shift_s[31:16]};
                        3'd3:    imm_s = {8'd0, shift_s[31:8]};
                        default: imm_s = shift_s;
                    endcase
                    casez (op_r)
                        8'h17: rfp_nx_s = imm_s[1:0];
                        8'h1A: pc_nx_s  = {8'h00, imm_s[15:0]};
                        8'h1B: pc_nx_s  = imm_s[23:0];
                        8'b0010_0???: begin
                            // Byte codes W,A,B,C,... map to offsets 1,0,5,4,...
                            wr_en_s   = 1'b1;
                            wr_base_s = bank_base_s + {3'b000, op_r[2:1], 1'b0, ~op_r[0]};
                            wr_len_s  = 3'd1;
                            wr_data_s = imm_s;
                        end
                        8'b0011_0???: begin
                            wr_en_s   = 1'b1;
                            wr_base_s = reg_base_s;
                            wr_len_s  = 3'd2;
                            wr_data_s = imm_s;
                        end
                        8'b0100_0???: begin
                            wr_en_s   = 1'b1;
                            wr_base_s = reg_base_s;
                            wr_len_s  = 3'd4;
                            wr_data_s = imm_s;
                        end
                        default: wr_en_s = 1'b0;
                    endcase
                end else begin
                    state_nx_s = FETCH_IMM;
                end
            end
            default: state_nx_s = FETCH_OP;
        endcase
    end

    // Per-byte write enables and data for the register file, little-endian from wr_base_s.
    always_comb begin
        logic [6:0] off;
        for (int i = 0; i < 80; i++) begin
            off      = 7'(i) - wr_base_s;
            be_s[i]  = wr_en_s && (off < {4'b0000, wr_len_s});
            case (off[1:0])
                2'd0:    bd_s[i] = wr_data_s[7:0];
                2'd1:    bd_s[i] = wr_data_s[15:8];
                2'd2:    bd_s[i] = wr_data_s[23:16];
                default: bd_s[i] = wr_data_s[31:24];
            endcase
        end
    end

    // Control state, PC and bank pointer; everything holds while cen is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= FETCH_OP;
            op_r    <= 8'd0;
            cnt_r   <= 3'd0;
            buf_r   <= 24'd0;
            pc_r    <= 24'd0;
            rfp_r   <= 2'd0;
        end else if (cen) begin
            state_r <= state_nx_s;
            op_r    <= op_nx_s;
            cnt_r   <= cnt_nx_s;
            buf_r   <= buf_nx_s;
            pc_r    <= pc_nx_s;
            rfp_r   <= rfp_nx_s;
        end
    end

    // Register file storage, written on the edge that fetches the last immediate byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 80; i++) begin
                regs_r[i] <= 8'd0;
            end
        end else if (cen) begin
            for (int i = 0; i < 80; i++) begin
                if (be_s[i]) begin
                    regs_r[i] <= bd_s[i];
                end
            end
        end
    end

    // Dump port: one-cycle registered read, independent of cen; out-of-range reads 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dmp_din_r <= 8'd0;
        end else if (dmp_addr < 8'd80) begin
            dmp_din_r <= regs_r[dmp_addr[6:0]];
        end else begin
            dmp_din_r <= 8'd0;
        end
    end

    assign ram_addr = pc_r;
    assign dmp_din  = dmp_din_r;

endmodule

// File: tb/tb_jt900h_core.sv
// Testbench for jt900h_core: directed programs plus random programs checked
// against an instruction-level interpreter of the register/PC semantics.
module tb_jt900h_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cen = 1'b0;
    logic [23:0] ram_addr;
    logic [15:0] ram_dout;
    logic [7:0]  dmp_addr = 8'd0;
    logic [7:0]  dmp_din;

    logic [7:0]  mem [256];

    jt900h_core dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .ram_addr (ram_addr),
        .ram_dout (ram_dout),
        .dmp_addr (dmp_addr),
        .dmp_din  (dmp_din)
    );

    assign ram_dout = {mem[{ram_addr[7:1], 1'b1}], mem[{ram_addr[7:1], 1'b0}]};

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [23:0] m_pc;
    logic [1:0]  m_rfp;
    logic [7:0]  m_regs [80];
    int          byte_off [8] = '{1, 0, 5, 4, 9, 8, 13, 12};

    function automatic int lbase(input int r, input int bank);
        if (r < 4) return 16 * bank + 4 * r;
        else       return 64 + 4 * (r - 4);
    endfunction

    task automatic m_reset();
        m_pc  = 24'd0;
        m_rfp = 2'd0;
        for (int i = 0; i < 80; i++) m_regs[i] = 8'd0;
    endtask

    // Interpret one instruction; returns its length in bytes.
    task automatic m_step(output int len);
        logic [7:0] op;
        logic [7:0] b [4];
        int n, r, base;
        op = mem[m_pc[7:0]];
        m_pc = m_pc + 24'd1;
        if (op == 8'h17) n = 1;
        else if (op == 8'h1A) n = 2;
        else if (op == 8'h1B) n = 3;
        else if (op >= 8'h20 && op <= 8'h27) n = 1;
        else if (op >= 8'h30 && op <= 8'h37) n = 2;
        else if (op >= 8'h40 && op <= 8'h47) n = 4;
        else n = 0;
        for (int i = 0; i < 4; i++) b[i] = 8'd0;
        for (int i = 0; i < n; i++) begin
            b[i] = mem[m_pc[7:0]];
            m_pc = m_pc + 24'd1;
        end
        len = n + 1;
        r = int'(op[2:0]);
        if (op == 8'h17) m_rfp = b[0][1:0];
        else if (op == 8'h1A) m_pc = {8'h00, b[1], b[0]};
        else if (op == 8'h1B) m_pc = {b[2], b[1], b[0]};
        else if (n == 1) m_regs[16 * int'(m_rfp) + byte_off[r]] = b[0];
        else if (n == 2) begin
            base = lbase(r, int'(m_rfp));
            m_regs[base] = b[0];
            m_regs[base + 1] = b[1];
        end else if (n == 4) begin
            base = lbase(r, int'(m_rfp));
            for (int i = 0; i < 4; i++) m_regs[base + i] = b[i];
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick(input logic en);
        @(negedge clk);
        cen = en;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        cen = 1'b0;
        m_reset();
        @(negedge clk);
        check("reset_pc", {8'd0, ram_addr}, 32'd0);
        check("reset_dmp", {24'd0, dmp_din}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic load(input logic [7:0] prog [$]);
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < prog.size(); i++) mem[i] = prog[i];
    endtask

    task automatic rd_dmp(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        cen = 1'b0;
        dmp_addr = a;
        @(posedge clk);
        #1;
        d = dmp_din;
    endtask

    task automatic get32(input int base, output logic [31:0] v);
        logic [7:0] d;
        v = 32'd0;
        for (int i = 0; i < 4; i++) begin
            rd_dmp(8'(base + i), d);
            v[8*i +: 8] = d;
        end
    endtask

    // Sweep dump addresses 0..80 plus one far out-of-range index with cen low.
    task automatic dump_all(input string tag);
        logic [7:0] d;
        for (int a = 0; a <= 80; a++) begin
            rd_dmp(8'(a), d);
            check(tag, {16'(a), 8'd0, d}, {16'(a), 8'd0, (a < 80) ? m_regs[a] : 8'd0});
        end
        rd_dmp(8'd255, d);
        check({tag, "_oob"}, {24'd0, d}, 32'd0);
    endtask

    // Run instructions on model and DUT, optionally inserting cen-low gaps.
    task automatic run_instrs(input int count, input bit gaps);
        int len, g;
        logic [23:0] pc_start;
        for (int k = 0; k < count; k++) begin
            pc_start = m_pc;
            m_step(len);
            for (int c = 0; c < len; c++) begin
                if (gaps && $urandom_range(0, 7) == 0) begin
                    g = $urandom_range(1, 5);
                    for (int j = 0; j < g; j++) begin
                        tick(1'b0);
                        check("gap_hold", {8'd0, ram_addr}, {8'd0, 24'(pc_start + 24'(c))});
                    end
                end
                tick(1'b1);
            end
            check("instr_pc", {8'd0, ram_addr}, {8'd0, m_pc});
        end
    endtask

    task automatic gen_random_prog();
        int a, kind;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        a = 0;
        while (a < 250) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0: begin mem[a] = 8'h00; a += 1; end
                1: begin mem[a] = 8'h17; mem[a+1] = 8'($urandom); a += 2; end
                2, 3: begin mem[a] = 8'h20 + 8'($urandom_range(0, 7)); mem[a+1] = 8'($urandom); a += 2; end
                4: begin mem[a] = 8'h30 + 8'($urandom_range(0, 7)); mem[a+1] = 8'($urandom); mem[a+2] = 8'($urandom); a += 3; end
                5, 6: begin
                    mem[a] = 8'h40 + 8'($urandom_range(0, 7));
                    for (int i = 1; i <= 4; i++) mem[a+i] = 8'($urandom);
                    a += 5;
                end
                7: begin mem[a] = 8'h1A; mem[a+1] = 8'($urandom); mem[a+2] = 8'($urandom_range(0, 1)); a += 3; end
                8: begin mem[a] = 8'h1B; mem[a+1] = 8'($urandom); mem[a+2] = 8'($urandom); mem[a+3] = 8'($urandom); a += 4; end
                default: begin mem[a] = 8'($urandom); a += 1; end
            endcase
        end
    endtask

    logic [31:0] v;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        m_reset();

        // Reset then idle
        do_reset();
        check("idle_pc", {8'd0, ram_addr}, 32'd0);
        dump_all("reset_dump");
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            tick(1'b1);
            check("nop_pc", {8'd0, ram_addr}, 32'(i));
        end

        // Long load into XWA
        load('{8'h40, 8'h78, 8'h56, 8'h34, 8'h12});
        do_reset();
        run_instrs(1, 1'b0);
        get32(0, v);
        check("xwa_long", v, 32'h12345678);

        // Long load into XSP
        load('{8'h47, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
        do_reset();
        run_instrs(1, 1'b0);
        get32(76, v);
        check("xsp_long", v, 32'hDEADBEEF);

        // Byte and word merge
        load('{8'h40, 8'h44, 8'h33, 8'h22, 8'h11, 8'h21, 8'hAA, 8'h20, 8'hBB, 8'h30, 8'hCD, 8'hAB});
        do_reset();
        run_instrs(3, 1'b0);
        get32(0, v);
        check("merge_bytes", v, 32'h1122BBAA);
        run_instrs(1, 1'b0);
        get32(0, v);
        check("merge_word", v, 32'h1122ABCD);

        // Bank switch
        load('{8'h17, 8'h02, 8'h41, 8'h04, 8'h03, 8'h02, 8'h01});
        do_reset();
        run_instrs(2, 1'b0);
        get32(36, v);
        check("bank2_xbc", v, 32'h01020304);
        get32(4, v);
        check("bank0_xbc", v, 32'h00000000);
        dump_all("bank_dump");

        // Jump latency
        load('{8'h1A, 8'h10, 8'h00});
        do_reset();
        tick(1'b1); check("jp_c1", {8'd0, ram_addr}, 32'd1);
        tick(1'b1); check("jp_c2", {8'd0, ram_addr}, 32'd2);
        tick(1'b1); check("jp_c3", {8'd0, ram_addr}, 32'h10);

        // PC wrap via JP nnn to the top address
        load('{8'h1B, 8'hFF, 8'hFF, 8'hFF});
        do_reset();
        repeat (4) tick(1'b1);
        check("wrap_top", {8'd0, ram_addr}, 32'h00FFFFFF);
        tick(1'b1);
        check("wrap_zero", {8'd0, ram_addr}, 32'd0);

        // Gated enable mid-instruction
        load('{8'h40, 8'h78, 8'h56, 8'h34, 8'h12});
        do_reset();
        tick(1'b1);
        tick(1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0);
            check("cen_frozen", {8'd0, ram_addr}, 32'd2);
        end
        repeat (3) tick(1'b1);
        check("cen_resume_pc", {8'd0, ram_addr}, 32'd5);
        get32(0, v);
        check("cen_resume_xwa", v, 32'h12345678);

        // Reset mid-instruction aborts it
        load('{8'h40, 8'h11, 8'h22, 8'h33, 8'h44});
        do_reset();
        repeat (3) tick(1'b1);
        do_reset();
        get32(0, v);
        check("abort_xwa", v, 32'h00000000);
        tick(1'b1);
        check("abort_refetch", {8'd0, ram_addr}, 32'd1);

        // Randomized programs against the interpreter
        for (int t = 0; t < 6; t++) begin
            gen_random_prog();
            do_reset();
            run_instrs(40, 1'b1);
            dump_all("rand_dump");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jt900h_core.md
# jt900h_core

Reduced TLCS-900H-style CPU core. It fetches instruction bytes from a 16-bit read-only program memory, executes a subset of immediate loads, register-bank selection and absolute jumps, and exposes its 80-byte register file through a byte-wide debug dump port. It sits at the top of the CPU simulation harness, which uses the dump port to snapshot register state at the end of a program.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  — system clock. All state changes on the rising edge.
- `rst`  in  1  — asynchronous, active-low reset. 0 = reset.
- `cen`  in  1  — clock enable. When 0, fetch and execute are frozen. The dump port keeps working.
- `ram_addr`  out  24  — byte address of the next instruction byte. Equals PC.
- `ram_dout`  in  16  — program memory word at `{ram_addr[23:1],0}`. Combinational, valid in the same cycle.
  - `[7:0]` holds the even byte; `[15:8]` holds the odd byte.
- `dmp_addr`  in  8  — register-file byte index, 0–79.
- `dmp_din`  out  8  — registered read of the register-file byte at `dmp_addr`.

## Operation
Register file: 80 bytes, all multi-byte values little-endian.
- Bytes 0–63 are four banks of 16 bytes. Bank b starts at 16·b and holds XWA, XBC, XDE, XHL at offsets +0, +4, +8, +12.
- Within XWA: byte 0 = A, byte 1 = W, bytes 2–3 = upper word. XBC, XDE and XHL follow the same pattern (C,B / E,D / L,H).
- Bytes 64–79: XIX, XIY, XIZ, XSP at 64, 68, 72, 76. These are not banked.
- RFP is a 2-bit current-bank pointer.

Register codes r (0–7), used by the opcode table:
- Byte code r: W, A, B, C, D, E, H, L, all in the current bank.
- Word code r: WA, BC, DE, HL, IX, IY, IZ, SP.
- Long code r: XWA, XBC, XDE, XHL, XIX, XIY, XIZ, XSP.

Fetch:
- One byte per `cen`-high cycle, taken from `ram_addr[0] ? ram_dout[15:8] : ram_dout[7:0]`.
- PC increments by 1 per byte fetched.

Opcodes. Immediates are little-endian; all unlisted opcodes are a 1-byte NOP.
- `0x00` — NOP.
- `0x17 n` — LDF: RFP ← n[1:0].
- `0x1A lo hi` — JP nn: PC ← {8'h00, hi, lo}.
- `0x1B b0 b1 b2` — JP nnn: PC ← {b2, b1, b0}.
- `0x20+r n` — LD byte register r ← n.
- `0x30+r lo hi` — LD word register r ← {hi, lo}. The upper word of the long register is unchanged.
- `0x40+r b0 b1 b2 b3` — LD long register r ← {b3, b2, b1, b0}.

Control:
- Small FSM with states FETCH_OP and FETCH_IMM. It tracks the number of remaining immediate bytes (0–4) in a byte shift buffer.
- The register or PC write happens on the edge at which the last immediate byte is fetched.
- The dump read is independent of `cen` and of the FSM state.

Reset:
- PC = 0, RFP = 0, all 80 register bytes = 0, FSM = FETCH_OP, `dmp_din` = 0.

## Timing
- Instruction latency equals its byte count in `cen`-high cycles: NOP 1, LDF 2, JP nn 3, JP nnn 4, LD byte 2, LD word 3, LD long 5. No extra cycles.
- A jump takes effect on the next fetch: the cycle after the last JP byte fetches from the target.
- `cen` = 0 mid-instruction: all state, including partial immediates, holds. The instruction resumes when `cen` returns to 1.
- `dmp_din` = regfile[`dmp_addr`] of the previous cycle (1-cycle latency). For `dmp_addr` ≥ 80, `dmp_din` = 0.
- Reset asserted mid-instruction aborts it. After release, the first fetch is from address 0 on the first `cen`-high edge.
- PC wraps from 0xFFFFFF to 0.

## Test plan
- Reset then idle:
  - After reset, `ram_addr` = 0 and every dump byte reads 0.
  - A program of only NOPs advances `ram_addr` by 1 per cycle.
- Long loads into the current bank and the index registers:
  - Program `40 78 56 34 12` → dump bytes 0–3 = 78 56 34 12 (XWA = 0x12345678).
  - Program `47 EF BE AD DE` → XSP (bytes 76–79) = 0xDEADBEEF.
- Byte and word merge: `40 44 33 22 11`, `21 AA`, `20 BB`, `30 CD AB` → XWA = 0x1122ABCD.
  - The `30` load overwrites A and W but leaves the upper word untouched.
- Bank switch: `17 02`, `41 04 03 02 01` → bank-2 XBC (bytes 36–39) = 0x01020304; bank 0 stays 0.
- Jump: `1A 10 00` at address 0 → the next `ram_addr` is 0x000010 after exactly 3 cycles.
- Gated enable:
  - `cen` low for 5 cycles in the middle of `40 …` → same final value, and `ram_addr` frozen during the gap.
  - With `cen` low, sweeping `dmp_addr` 0..80 returns each byte one cycle later.
